// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort_emitter batch sorter.
package sort_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage : sort_pkg

// File: rtl/sort_slot.sv
// One entry of the sorting array: compares against the incoming word and
// selects between hold, insert (from din or from the previous slot) and
// shift-in from the next slot.
// Ordering: descending by default; define SORT_EMITTER_ASCEND_EN for ascending.
module sort_slot
  import sort_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ins_en,
  input  logic          shift_en,
  input  logic          occupied,
  input  logic          prev_keep,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] prev_q,
  input  logic [DW-1:0] next_q,
  output logic [DW-1:0] q,
  output logic          keep_c
);

  // Stored word stays ahead of the new one on ties, which keeps insertion stable.
  always_comb begin
`ifdef SORT_EMITTER_ASCEND_EN
    keep_c = occupied && (q <= din);
`else
    keep_c = occupied && (q >= din);
`endif
  end

  // Slot register: hold, take the new word, move down for an insert, or move up on emit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ins_en) begin
      if (!keep_c) begin
        q <= prev_keep ? din : prev_q;
      end
    end else if (shift_en) begin
      q <= next_q;
    end
  end

endmodule : sort_slot

// File: rtl/sort_emitter.sv
// Batch sorter: loads up to DEPTH words with insertion into an ordered
// register array, then emits them in order over a valid/ready port.
// Optional macro SORT_EMITTER_ASCEND_EN selects ascending order.
module sort_emitter
  import sort_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ins_en, shift_en;
  logic           in_fire_c, out_fire_c;

  logic [DW-1:0]    slot_q [DEPTH];
  logic [DW-1:0]    prev_q [DEPTH];
  logic [DW-1:0]    next_q [DEPTH];
  logic [DEPTH-1:0] keep;
  logic [DEPTH-1:0] prev_keep;
  logic [DEPTH-1:0] occ;

  assign in_fire_c  = in_valid && in_ready && (state_q == ST_LOAD);
  assign out_fire_c = out_valid && out_ready && (state_q == ST_EMIT);
  assign out_data   = slot_q[0];

  // Array of slots, each wired to its neighbours; the ends see zero/always-keep.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_slot
    assign occ[i] = (CW'(i) < count_q);

    if (i == 0) begin : g_head
      assign prev_q[i]    = '0;
      assign prev_keep[i] = 1'b1;
    end else begin : g_body
      assign prev_q[i]    = slot_q[i-1];
      assign prev_keep[i] = keep[i-1];
    end

    if (i == int'(DEPTH) - 1) begin : g_tail
      assign next_q[i] = '0;
    end else begin : g_mid
      assign next_q[i] = slot_q[i+1];
    end

    sort_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .ins_en    (ins_en),
      .shift_en  (shift_en),
      .occupied  (occ[i]),
      .prev_keep (prev_keep[i]),
      .din       (in_data),
      .prev_q    (prev_q[i]),
      .next_q    (next_q[i]),
      .q         (slot_q[i]),
      .keep_c    (keep[i])
    );
  end

  // Next-state, count and array control.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ins_en   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_fire_c) begin
          ins_en  = 1'b1;
          count_d = count_q + CW'(1);
          if (in_last || (count_q == CW'(DEPTH - 1))) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_fire_c) begin
          shift_en = 1'b1;
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State, count and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      count_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      in_ready  <= (state_d == ST_LOAD);
      out_valid <= (state_d == ST_EMIT);
      out_last  <= (state_d == ST_EMIT) && (count_d == CW'(1));
      busy      <= (count_d != '0);
    end
  end

endmodule : sort_emitter

// File: tb/tb_sort_emitter.sv
// Testbench for sort_emitter: directed batches plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_sort_emitter;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cur[$];
  int  expq[$];
  bit  post_rst = 1'b1;
  bit  rand_on  = 1'b0;

  always #5 clk = ~clk;

  sort_emitter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Completed batch: emit order is the stable sort of the accepted words.
  function automatic void close_batch();
    while (cur.size() > 0) begin
      int bi = 0;
      for (int k = 1; k < cur.size(); k++) begin
`ifdef SORT_EMITTER_ASCEND_EN
        if (cur[k] < cur[bi]) bi = k;
`else
        if (cur[k] > cur[bi]) bi = k;
`endif
      end
      expq.push_back(cur[bi]);
      cur.delete(bi);
    end
  endfunction

  // Reference model and per-cycle checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (post_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
    end else begin
      chk("in_ready", in_ready, expq.size() == 0);
      chk("out_valid", out_valid, expq.size() != 0);
      chk("busy", busy, (cur.size() + expq.size()) != 0);
      if (expq.size() != 0) begin
        chk("out_data", out_data, expq[0]);
        chk("out_last", out_last, expq.size() == 1);
      end
    end
    if (!rst_n) begin
      cur.delete();
      expq.delete();
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (in_valid && in_ready) begin
        cur.push_back(int'(in_data));
        if (in_last || cur.size() == int'(DEPTH)) close_batch();
      end
      if (out_valid && out_ready && expq.size() != 0) void'(expq.pop_front());
    end
  end

  task automatic push_word(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    chk("in_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input int v[$], input bit use_last, input bit gaps);
    for (int k = 0; k < v.size(); k++) begin
      push_word(v[k], use_last && (k == v.size() - 1));
      if (gaps) repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0 && cur.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int v[$];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full batch ended by depth.
    v = '{3, 9, 1, 7, 9, 0, 5, 2};
    send(v, 1'b0, 1'b0);
    wait_idle();

    // Short batch ended by in_last.
    v = '{4, 8, 6};
    send(v, 1'b1, 1'b0);
    wait_idle();

    // Output backpressure holds the first word.
    out_ready = 1'b0;
    v = '{2, 5};
    send(v, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Input held valid through emission must wait for the next batch.
    v = '{10, 20};
    send(v, 1'b1, 1'b0);
    v = '{170};
    send(v, 1'b1, 1'b0);
    wait_idle();

    // Reset in the middle of emission.
    out_ready = 1'b0;
    v = '{1, 2, 3};
    send(v, 1'b1, 1'b0);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    v = '{7};
    send(v, 1'b1, 1'b0);
    wait_idle();

    // Order check for small batch (ascending or descending per build).
    v = '{3, 9, 1};
    send(v, 1'b1, 1'b0);
    wait_idle();

    // Randomized batches with random backpressure and occasional resets.
    rand_on = 1'b1;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          int len;
          len = $urandom_range(1, 10);
          v.delete();
          for (int k = 0; k < len; k++) begin
            if (b % 3 == 0) v.push_back($urandom_range(0, 255));
            else            v.push_back($urandom_range(0, 15));
          end
          send(v, 1'b1, 1'b1);
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1;
          if ($urandom_range(0, 9) == 0) rst_pulse();
        end
        wait_idle();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sort_emitter
